// File: rtl/bkram_sd_ctrl.sv
// bkram_sd_ctrl
// Sequences backup (save) RAM transfers between the nvram dual-port RAM and the
// host SD image through the user_io sector interface. A load (read) runs on
// every valid image mount; a save (write) runs on an OSD request or, when
// AUTOSAVE_CYC is non-zero, after the nvram has been idle that many cycles
// following a write. A completed load emits a one-cycle bk_reset pulse.
//
// Ports
//   clk_sys      system clock
//   reset        synchronous active-high global reset
//   img_mounted  host mount strobe (edge-detected)
//   img_size     mounted image size in bytes, 0 = unmount
//   ioctl_dl     ROM download active; its rising edge disables and aborts
//   save_req     OSD save request, rising edge = request
//   nvram_we     core write strobe into nvram (dirty tracking)
//   sd_ack       host sector acknowledge
//   sd_lba       sector address
//   sd_rd/sd_wr  sector read / write request
//   bk_ena       valid save image mounted
//   bk_reset     one-cycle pulse after a completed load
//   busy         transfer in progress
//   dirty        nvram written since the last save started
module bkram_sd_ctrl #(
    parameter int SECTORS      = 16,
    parameter int AUTOSAVE_CYC = 0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic [31:0] img_size,
    input  logic        ioctl_dl,
    input  logic        save_req,
    input  logic        nvram_we,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        bk_ena,
    output logic        bk_reset,
    output logic        busy,
    output logic        dirty
);

    localparam int LW = (SECTORS > 1) ? $clog2(SECTORS) : 1;
    localparam logic [LW-1:0] LAST_LBA = LW'(SECTORS - 1);
    localparam logic [31:0]   AUTO_LIM = 32'(AUTOSAVE_CYC);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAITLO = 3'd1;
    localparam logic [2:0] ST_REQ    = 3'd2;
    localparam logic [2:0] ST_ACK    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]    state_r;
    logic [LW-1:0] lba_r;
    logic          dir_r;        // 1 = load (read), 0 = save (write)
    logic          abort_r;      // download started mid-transfer
    logic          load_pend_r;
    logic          save_pend_r;
    logic          bk_ena_r;
    logic          bk_reset_r;
    logic          sd_rd_r;
    logic          sd_wr_r;
    logic          dirty_r;
    logic [31:0]   cnt_r;
    logic          mount_d_r;
    logic          dl_d_r;
    logic          save_d_r;

    logic mount_edge_s;
    logic dl_edge_s;
    logic save_edge_s;
    logic idle_s;
    logic autosave_s;
    logic start_load_s;
    logic start_save_s;
    logic abort_now_s;

    assign mount_edge_s = img_mounted & ~mount_d_r;
    assign dl_edge_s    = ioctl_dl & ~dl_d_r;
    assign save_edge_s  = save_req & ~save_d_r;
    assign idle_s       = (state_r == ST_IDLE);
    assign abort_now_s  = abort_r | dl_edge_s;

    assign autosave_s   = (AUTOSAVE_CYC != 0) && dirty_r && bk_ena_r && idle_s
                          && (cnt_r == AUTO_LIM);

    // A download edge in the same cycle suppresses any start; load beats save.
    assign start_load_s = idle_s & bk_ena_r & ~dl_edge_s & load_pend_r;
    assign start_save_s = idle_s & bk_ena_r & ~dl_edge_s & ~load_pend_r
                          & (save_pend_r | save_edge_s | autosave_s);

    // Edge-detector history; sampling during reset primes it with live inputs.
    always_ff @(posedge clk_sys) begin
        mount_d_r <= img_mounted;
        dl_d_r    <= ioctl_dl;
        save_d_r  <= save_req;
    end

    // Dirty flag and saturating idle counter for autosave.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dirty_r <= 1'b0;
            cnt_r   <= 32'd0;
        end else if (nvram_we) begin
            // A write during a save start keeps dirty set so a later save repeats.
            dirty_r <= 1'b1;
            cnt_r   <= 32'd0;
        end else begin
            if (start_save_s) begin
                dirty_r <= 1'b0;
            end
            if (cnt_r != AUTO_LIM) begin
                cnt_r <= cnt_r + 32'd1;
            end
        end
    end

    // Enable/pending bookkeeping and the transfer sequencer.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            lba_r       <= '0;
            dir_r       <= 1'b0;
            abort_r     <= 1'b0;
            load_pend_r <= 1'b0;
            save_pend_r <= 1'b0;
            bk_ena_r    <= 1'b0;
            bk_reset_r  <= 1'b0;
            sd_rd_r     <= 1'b0;
            sd_wr_r     <= 1'b0;
        end else begin
            bk_reset_r <= 1'b0;

            if (start_load_s) begin
                load_pend_r <= 1'b0;
            end
            if (start_save_s) begin
                save_pend_r <= 1'b0;
            end else if (save_edge_s && bk_ena_r) begin
                save_pend_r <= 1'b1;
            end
            if (mount_edge_s) begin
                if (img_size != 32'd0) begin
                    bk_ena_r    <= 1'b1;
                    load_pend_r <= 1'b1;
                end else begin
                    bk_ena_r <= 1'b0;
                end
            end
            // Download edge overrides everything above.
            if (dl_edge_s) begin
                bk_ena_r    <= 1'b0;
                load_pend_r <= 1'b0;
                save_pend_r <= 1'b0;
                if (!idle_s) begin
                    abort_r <= 1'b1;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (start_load_s || start_save_s) begin
                        dir_r   <= start_load_s;
                        lba_r   <= '0;
                        abort_r <= 1'b0;
                        state_r <= ST_WAITLO;
                    end
                end
                ST_WAITLO: begin
                    // Wait out an ack left high from before a reset.
                    if (abort_now_s) begin
                        state_r <= ST_IDLE;
                    end else if (!sd_ack) begin
                        sd_rd_r <= dir_r;
                        sd_wr_r <= ~dir_r;
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sd_ack) begin
                        sd_rd_r <= 1'b0;
                        sd_wr_r <= 1'b0;
                        state_r <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!sd_ack) begin
                        if (abort_now_s || (lba_r == LAST_LBA)) begin
                            state_r <= ST_DONE;
                        end else begin
                            lba_r   <= lba_r + LW'(1);
                            sd_rd_r <= dir_r;
                            sd_wr_r <= ~dir_r;
                            state_r <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    bk_reset_r <= dir_r & ~abort_now_s;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    sd_rd_r <= 1'b0;
                    sd_wr_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign sd_lba   = {{(32 - LW){1'b0}}, lba_r};
    assign sd_rd    = sd_rd_r;
    assign sd_wr    = sd_wr_r;
    assign bk_ena   = bk_ena_r;
    assign bk_reset = bk_reset_r;
    assign busy     = ~idle_s;
    assign dirty    = dirty_r;

endmodule
